ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Four-master AHB bus arbiter and address/data multiplexer.
// A master keeps the bus until it releases it, goes IDLE, sees an ERROR
// response, or uses up its beat budget outside a SEQ burst. The next owner
// is picked round-robin, starting at the master after the current owner.
// With no requester the bus parks on DEFAULT_MASTER.
//
// Ports
//   clock, Hreset              : clock, asynchronous active-high reset
//   m_Hbusreq/Htrans/Haddr/... : packed per-master request and bus signals
//   s_Hreadyout, s_Hresp       : slave ready and response
//   Hgrant, Hmaster, Hmaster_d : registered grant, address/data phase owner
//   Htrans..Hwdata, Hsel       : muxed slave-side bus
//   Hreadyin, m_Hresp          : ready and response broadcast to all masters
// ---------------------------------------------------------------------------
module ahb_arbiter #(
  parameter int unsigned MAX_BEATS      = 16,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic         clock,
  input  logic         Hreset,
  input  logic [3:0]   m_Hbusreq,
  input  logic [7:0]   m_Htrans,
  input  logic [127:0] m_Haddr,
  input  logic [3:0]   m_Hwrite,
  input  logic [11:0]  m_Hsize,
  input  logic [127:0] m_Hwdata,
  input  logic         s_Hreadyout,
  input  logic [1:0]   s_Hresp,
  output logic [3:0]   Hgrant,
  output logic [1:0]   Hmaster,
  output logic [1:0]   Hmaster_d,
  output logic [1:0]   Htrans,
  output logic [31:0]  Haddr,
  output logic         Hwrite,
  output logic [2:0]   Hsize,
  output logic [31:0]  Hwdata,
  output logic         Hsel,
  output logic         Hreadyin,
  output logic [1:0]   m_Hresp
);

  localparam int unsigned NUM_M = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  localparam logic [IDX_W-1:0] DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [NUM_M-1:0] GRANT_ONE = NUM_M'(1);

  typedef enum logic {PARK, OWN} state_t;

  state_t             state_q,  state_d;
  logic [IDX_W-1:0]   owner_q,  owner_d;
  logic [IDX_W-1:0]   downer_q, downer_d;
  logic [NUM_M-1:0]   grant_q,  grant_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               err_q,    err_d;

  logic [1:0]         own_trans;
  logic [3:0]         size_idx;
  logic               cnt_hit;
  logic               arb_pt;
  logic               found;
  logic [IDX_W-1:0]   next_own;
  logic [IDX_W-1:0]   cand;

  // Slave-side bus mux: address phase from owner, write data from data-phase owner
  always_comb begin
    size_idx  = 4'(owner_q) * 4'd3;
    own_trans = m_Htrans[{owner_q, 1'b0} +: 2];
    Htrans    = (state_q == OWN) ? own_trans : TRANS_IDLE;
    Haddr     = m_Haddr[{owner_q, 5'b0} +: 32];
    Hwrite    = m_Hwrite[owner_q];
    Hsize     = m_Hsize[size_idx +: 3];
    Hwdata    = m_Hwdata[{downer_q, 5'b0} +: 32];
    Hsel      = (state_q == OWN);
    Hreadyin  = s_Hreadyout;
    m_Hresp   = s_Hresp;
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = owner_q;
  assign Hmaster_d = downer_q;

  // Round-robin search; k=NUM_M wraps back to the current owner, so it is checked last
  always_comb begin
    found    = 1'b0;
    next_own = owner_q;
    cand     = owner_q;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = owner_q + IDX_W'(k);
      if (!found && m_Hbusreq[cand]) begin
        found    = 1'b1;
        next_own = cand;
      end
    end
  end

  // Budget only forces a handover outside a SEQ beat so bursts are never split
  always_comb begin
    cnt_hit = (32'(cnt_q) >= MAX_BEATS);
    arb_pt  = s_Hreadyout &&
              ((state_q == PARK) ||
               !m_Hbusreq[owner_q] ||
               (own_trans == TRANS_IDLE) ||
               (cnt_hit && (own_trans != TRANS_SEQ)) ||
               err_q);
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    downer_d = downer_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    err_d    = (s_Hresp == RESP_ERROR);

    if (s_Hreadyout) begin
      downer_d = owner_q;
      if (arb_pt) begin
        cnt_d = '0;
        if (found) begin
          state_d = OWN;
          owner_d = next_own;
        end else begin
          state_d = PARK;
          owner_d = DEF_IDX;
        end
        grant_d = GRANT_ONE << owner_d;
      end else if ((state_q == OWN) &&
                   ((own_trans == TRANS_NONSEQ) || (own_trans == TRANS_SEQ)) &&
                   (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= PARK;
      owner_q  <= DEF_IDX;
      downer_q <= DEF_IDX;
      grant_q  <= GRANT_ONE << DEF_IDX;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      downer_q <= downer_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed bench for ahb_arbiter: reset/park, grant latency and bus muxing,
// round-robin rotation, beat budget with a sole requester and a contender,
// SEQ burst protection, wait states, ERROR-forced handover, mid-tenure reset.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic         clock = 1'b0;
  logic         Hreset;
  logic [3:0]   m_Hbusreq;
  logic [7:0]   m_Htrans;
  logic [127:0] m_Haddr;
  logic [3:0]   m_Hwrite;
  logic [11:0]  m_Hsize;
  logic [127:0] m_Hwdata;
  logic         s_Hreadyout;
  logic [1:0]   s_Hresp;
  logic [3:0]   Hgrant;
  logic [1:0]   Hmaster;
  logic [1:0]   Hmaster_d;
  logic [1:0]   Htrans;
  logic [31:0]  Haddr;
  logic         Hwrite;
  logic [2:0]   Hsize;
  logic [31:0]  Hwdata;
  logic         Hsel;
  logic         Hreadyin;
  logic [1:0]   m_Hresp;

  logic [1:0]  tr [4];
  logic [31:0] ad [4];
  logic [31:0] wd [4];
  logic [2:0]  sz [4];
  logic        wr [4];

  int checks = 0;
  int errors = 0;

  assign m_Htrans = {tr[3], tr[2], tr[1], tr[0]};
  assign m_Haddr  = {ad[3], ad[2], ad[1], ad[0]};
  assign m_Hwdata = {wd[3], wd[2], wd[1], wd[0]};
  assign m_Hsize  = {sz[3], sz[2], sz[1], sz[0]};
  assign m_Hwrite = {wr[3], wr[2], wr[1], wr[0]};

  always #5 clock = ~clock;

  ahb_arbiter #(.MAX_BEATS(16), .DEFAULT_MASTER(0)) dut (
    .clock       (clock),
    .Hreset      (Hreset),
    .m_Hbusreq   (m_Hbusreq),
    .m_Htrans    (m_Htrans),
    .m_Haddr     (m_Haddr),
    .m_Hwrite    (m_Hwrite),
    .m_Hsize     (m_Hsize),
    .m_Hwdata    (m_Hwdata),
    .s_Hreadyout (s_Hreadyout),
    .s_Hresp     (s_Hresp),
    .Hgrant      (Hgrant),
    .Hmaster     (Hmaster),
    .Hmaster_d   (Hmaster_d),
    .Htrans      (Htrans),
    .Haddr       (Haddr),
    .Hwrite      (Hwrite),
    .Hsize       (Hsize),
    .Hwdata      (Hwdata),
    .Hsel        (Hsel),
    .Hreadyin    (Hreadyin),
    .m_Hresp     (m_Hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic all_trans(input logic [1:0] t);
    for (int i = 0; i < 4; i++) tr[i] = t;
  endtask

  logic [1:0] cur;
  logic [1:0] nxt;

  initial begin
    Hreset      = 1'b1;
    m_Hbusreq   = 4'b0000;
    s_Hreadyout = 1'b1;
    s_Hresp     = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tr[i] = IDLE;
      ad[i] = 32'h0000_0100 * 32'(i + 1);
      wd[i] = 32'hD000_0000 | 32'(i);
      sz[i] = 3'(i);
      wr[i] = 1'b0;
    end
    ad[2] = 32'h0000_1000;

    // Reset state, checked before any clock edge
    #2;
    chk("rst_grant",   32'(Hgrant),    32'h1);
    chk("rst_master",  32'(Hmaster),   32'h0);
    chk("rst_master_d",32'(Hmaster_d), 32'h0);
    chk("rst_htrans",  32'(Htrans),    32'h0);
    chk("rst_hsel",    32'(Hsel),      32'h0);
    tick();
    Hreset = 1'b0;

    // Parked for 10 cycles with no requests
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("park_grant",  32'(Hgrant), 32'h1);
      chk("park_hsel",   32'(Hsel),   32'h0);
      chk("park_htrans", 32'(Htrans), 32'h0);
    end
    chk("readyin_hi", 32'(Hreadyin), 32'h1);
    s_Hresp = 2'b10;
    #1;
    chk("resp_pass", 32'(m_Hresp), 32'h2);
    s_Hresp = 2'b00;

    // Grant latency and bus muxing for master 2
    m_Hbusreq = 4'b0100;
    tr[2] = NONSEQ; wr[2] = 1'b1;
    #1;
    chk("park_force_idle", 32'(Htrans), 32'h0);
    tick();
    chk("m2_grant",   32'(Hgrant),    32'h4);
    chk("m2_master",  32'(Hmaster),   32'h2);
    chk("m2_hsel",    32'(Hsel),      32'h1);
    chk("m2_haddr",   Haddr,          32'h0000_1000);
    chk("m2_htrans",  32'(Htrans),    32'h2);
    chk("m2_hwrite",  32'(Hwrite),    32'h1);
    chk("m2_hsize",   32'(Hsize),     32'h2);
    chk("m2_mdata0",  32'(Hmaster_d), 32'h0);
    chk("m2_wdata0",  Hwdata,         32'hD000_0000);
    tick();
    chk("m2_mdata1",  32'(Hmaster_d), 32'h2);
    chk("m2_wdata1",  Hwdata,         32'hD000_0002);
    chk("m2_hold",    32'(Hgrant),    32'h4);
    m_Hbusreq = 4'b0000; tr[2] = IDLE;
    tick();
    chk("m2_rel_grant",  32'(Hgrant),  32'h1);
    chk("m2_rel_hsel",   32'(Hsel),    32'h0);
    chk("m2_rel_master", 32'(Hmaster), 32'h0);

    // Round-robin rotation from owner 1
    m_Hbusreq = 4'b0010; tr[1] = NONSEQ;
    tick();
    chk("rr_own1", 32'(Hmaster), 32'h1);
    m_Hbusreq = 4'b1111; all_trans(NONSEQ);
    tick();
    chk("rr_own1_hold", 32'(Hgrant), 32'h2);
    cur = 2'd1;
    for (int s = 0; s < 4; s++) begin
      all_trans(NONSEQ);
      tr[cur] = IDLE;
      m_Hbusreq = 4'b1111 & ~(4'b0001 << cur);
      nxt = cur + 2'd1;
      tick();
      chk("rr_master", 32'(Hmaster), 32'(nxt));
      chk("rr_grant",  32'(Hgrant),  32'(4'b0001 << nxt));
      cur = nxt;
    end
    m_Hbusreq = 4'b0000; all_trans(IDLE);
    tick();
    chk("rr_park", 32'(Hgrant), 32'h1);

    // Master 3 sole requester: forced re-arbitration after 16 beats retains grant
    m_Hbusreq = 4'b1000; tr[3] = NONSEQ;
    tick();
    chk("sole_grant", 32'(Hgrant), 32'h8);
    for (int n = 0; n < 17; n++) tick();
    chk("sole_retain", 32'(Hgrant),  32'h8);
    chk("sole_master", 32'(Hmaster), 32'h3);
    // Budget restarted: a contender waits a full 16 beats again
    m_Hbusreq = 4'b1010; tr[1] = NONSEQ;
    for (int n = 0; n < 16; n++) tick();
    chk("budget_hold", 32'(Hgrant), 32'h8);
    tick();
    chk("budget_switch", 32'(Hgrant),  32'h2);
    chk("budget_master", 32'(Hmaster), 32'h1);
    m_Hbusreq = 4'b0000; all_trans(IDLE);
    tick();
    chk("budget_park", 32'(Hgrant), 32'h1);

    // SEQ burst past the budget is not split
    m_Hbusreq = 4'b0001; tr[0] = NONSEQ;
    tick();
    chk("seq_grant0", 32'(Hgrant), 32'h1);
    chk("seq_hsel",   32'(Hsel),   32'h1);
    tr[0] = SEQ; m_Hbusreq = 4'b0011; tr[1] = NONSEQ;
    for (int n = 0; n < 20; n++) tick();
    chk("seq_hold", 32'(Hgrant), 32'h1);
    tr[0] = NONSEQ;
    tick();
    chk("seq_switch", 32'(Hgrant), 32'h2);
    m_Hbusreq = 4'b0000; all_trans(IDLE);
    tick();
    chk("seq_park", 32'(Hgrant), 32'h1);

    // Wait states freeze the handover
    m_Hbusreq = 4'b0100; tr[2] = NONSEQ;
    tick();
    tick();
    chk("ws_setup", 32'(Hmaster_d), 32'h2);
    m_Hbusreq = 4'b0010; tr[2] = IDLE; tr[1] = NONSEQ;
    s_Hreadyout = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("ws_grant",    32'(Hgrant),    32'h4);
      chk("ws_master",   32'(Hmaster),   32'h2);
      chk("ws_master_d", 32'(Hmaster_d), 32'h2);
      chk("ws_readyin",  32'(Hreadyin),  32'h0);
    end
    s_Hreadyout = 1'b1;
    tick();
    chk("ws_switch",   32'(Hgrant),    32'h2);
    chk("ws_master1",  32'(Hmaster),   32'h1);
    chk("ws_mdata_old",32'(Hmaster_d), 32'h2);
    tick();
    chk("ws_mdata_new",32'(Hmaster_d), 32'h1);

    // ERROR response forces handover on the following edge
    m_Hbusreq = 4'b1010; tr[3] = NONSEQ;
    s_Hresp = 2'b01;
    tick();
    chk("err_same_cycle", 32'(Hgrant), 32'h2);
    s_Hresp = 2'b00;
    tick();
    chk("err_switch", 32'(Hgrant),  32'h8);
    chk("err_master", 32'(Hmaster), 32'h3);

    // Reset mid-tenure aborts it; arbitration restarts from PARK
    m_Hbusreq = 4'b1000;
    tick();
    Hreset = 1'b1;
    #1;
    chk("mrst_grant",    32'(Hgrant),    32'h1);
    chk("mrst_master",   32'(Hmaster),   32'h0);
    chk("mrst_master_d", 32'(Hmaster_d), 32'h0);
    chk("mrst_htrans",   32'(Htrans),    32'h0);
    chk("mrst_hsel",     32'(Hsel),      32'h0);
    tick();
    Hreset = 1'b0;
    tick();
    chk("mrst_regrant", 32'(Hgrant),  32'h8);
    chk("mrst_master3", 32'(Hmaster), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
